// File: rtl/stq_followingld_init_ctrl.sv
// stq_followingld_init_ctrl: zeroes the following-load RAM over active partitions, then forwards dispatch writes.
module stq_followingld_init_ctrl #(
  parameter int DEPTH     = 16,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 4,
  parameter int NUM_PARTS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reinit_i,
  input  logic [NUM_PORTS-1:0]       laneActive_i,
  input  logic [NUM_PARTS-1:0]       partActive_i,
  input  logic [NUM_PORTS-1:0]       dispWe_i,
  input  logic [NUM_PORTS*INDEX-1:0] dispAddr_i,
  input  logic [NUM_PORTS*WIDTH-1:0] dispData_i,
  output logic [NUM_PORTS-1:0]       ramWe_o,
  output logic [NUM_PORTS*INDEX-1:0] ramAddr_o,
  output logic [NUM_PORTS*WIDTH-1:0] ramData_o,
  output logic                       ready_o,
  output logic                       stall_o,
  output logic                       collision_o
);
  localparam int PS = DEPTH / NUM_PARTS;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nxt;
  logic [INDEX-1:0] cnt, cnt_nxt, next_addr;
  logic cur_on, have_next, coll_nxt;
  logic [NUM_PORTS-1:0] fwd, we_nxt;
  logic [NUM_PORTS*INDEX-1:0] addr_nxt;
  logic [NUM_PORTS*WIDTH-1:0] data_nxt;

  function automatic logic part_on(input logic [INDEX-1:0] a, input logic [NUM_PARTS-1:0] m);
    part_on = 1'b0;
    for (int p = 0; p < NUM_PARTS; p++)
      if (int'(a) / PS == p) part_on = m[p];
  endfunction

  always_comb begin
    cur_on = part_on(cnt, partActive_i);
    have_next = 1'b0;
    next_addr = '0;
    // lowest active partition above the current one, unless cnt can simply step within its own
    for (int p = NUM_PARTS-1; p >= 0; p--)
      if (p > int'(cnt) / PS && partActive_i[p]) begin
        have_next = 1'b1;
        next_addr = INDEX'(p * PS);
      end
    if (cur_on && int'(cnt) % PS != PS-1) begin
      have_next = 1'b1;
      next_addr = cnt + 1'b1;
    end
    for (int k = 0; k < NUM_PORTS; k++)
      fwd[k] = dispWe_i[k] & laneActive_i[k] & part_on(dispAddr_i[k*INDEX +: INDEX], partActive_i);
    state_nxt = state;
    cnt_nxt = cnt;
    we_nxt = '0;
    addr_nxt = '0;
    data_nxt = '0;
    coll_nxt = 1'b0;
    if (state == INIT) begin
      if (reinit_i) cnt_nxt = '0;
      else begin
        we_nxt[0] = cur_on;
        addr_nxt[INDEX-1:0] = cnt;
        cnt_nxt = have_next ? next_addr : '0;
        state_nxt = have_next ? INIT : READY;
      end
    end else begin
      addr_nxt = dispAddr_i;
      data_nxt = dispData_i;
      for (int k = 0; k < NUM_PORTS; k++) begin
        we_nxt[k] = fwd[k];
        for (int j = k + 1; j < NUM_PORTS; j++)
          if (fwd[k] && fwd[j] && dispAddr_i[k*INDEX +: INDEX] == dispAddr_i[j*INDEX +: INDEX]) begin
            we_nxt[k] = 1'b0;
            coll_nxt = 1'b1;
          end
      end
      if (reinit_i) begin
        state_nxt = INIT;
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
      ramWe_o <= '0;
      ramAddr_o <= '0;
      ramData_o <= '0;
      collision_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      ramWe_o <= we_nxt;
      ramAddr_o <= addr_nxt;
      ramData_o <= data_nxt;
      collision_o <= coll_nxt;
    end

  assign ready_o = state == READY;
  assign stall_o = ~ready_o;
endmodule
